// File: rtl/gpio_controller_if.sv
// ============================================================================
//  Module   : gpio_controller_if
//  Brief    : Data-memory request/response bus used by the GPIO controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gpio_controller_if;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wr_data;
  logic        i_req_wr_en;
  logic [1:0]  i_req_count;
  logic [31:0] o_res_rd_data;
  logic [1:0]  o_res_code;

  modport master (
    output i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count,
    input  o_res_rd_data, o_res_code
  );

  modport slave (
    input  i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count,
    output o_res_rd_data, o_res_code
  );
endinterface

`default_nettype wire

// File: rtl/gpio_controller.sv
// ============================================================================
//  Module   : gpio_controller
//  Brief    : Multi-bank memory-mapped GPIO with set/clear/toggle aliases,
//             synchronised inputs and edge interrupts (W1C status).
//             Count: 0 NONE, 1 BYTE, 2 HALF, 3 WORD.
//             Code : 0 NONE, 1 READ, 2 WRITE, 3 INVALID.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_controller #(
  parameter logic [31:0] ADDR_START  = 32'h0,
  parameter int          BANK_COUNT  = 1,
  parameter int          SYNC_STAGES = 2,
  parameter int          IRQ_EDGE    = 0,
  localparam int         GPIO_W      = BANK_COUNT * 32
) (
  input  wire logic              clk,
  input  wire logic              areset,
  gpio_controller_if.slave       bus,
  input  wire logic [GPIO_W-1:0] i_gpio_in,
  output logic      [GPIO_W-1:0] o_gpio_out,
  output logic      [GPIO_W-1:0] o_gpio_oe,
  output logic                   o_irq
);

  localparam logic [1:0]  c_cnt_none   = 2'd0;
  localparam logic [1:0]  c_cnt_byte   = 2'd1;
  localparam logic [1:0]  c_cnt_half   = 2'd2;
  localparam logic [1:0]  c_cnt_word   = 2'd3;
  localparam logic [1:0]  c_code_none  = 2'd0;
  localparam logic [1:0]  c_code_read  = 2'd1;
  localparam logic [1:0]  c_code_write = 2'd2;
  localparam logic [1:0]  c_code_inv   = 2'd3;
  localparam logic [2:0]  c_reg_out    = 3'd0;
  localparam logic [2:0]  c_reg_oe     = 3'd1;
  localparam logic [2:0]  c_reg_in     = 3'd2;
  localparam logic [2:0]  c_reg_set    = 3'd3;
  localparam logic [2:0]  c_reg_clr    = 3'd4;
  localparam logic [2:0]  c_reg_tgl    = 3'd5;
  localparam logic [2:0]  c_reg_ie     = 3'd6;
  localparam logic [2:0]  c_reg_is     = 3'd7;
  localparam logic [31:0] c_span       = 32'(BANK_COUNT * 32);

  logic [31:0]       r_out  [BANK_COUNT];
  logic [31:0]       r_oe   [BANK_COUNT];
  logic [31:0]       r_ie   [BANK_COUNT];
  logic [31:0]       r_is   [BANK_COUNT];
  logic [GPIO_W-1:0] r_sync [SYNC_STAGES];
  logic [GPIO_W-1:0] r_hist;
  logic [31:0]       r_rd_data;
  logic [1:0]        r_code;

  logic [31:0]       w_off;
  logic              w_in_range;
  logic [2:0]        w_bank;
  logic [2:0]        w_reg;
  logic [1:0]        w_lane;
  logic              w_aligned;
  logic [31:0]       w_mask;
  logic [4:0]        w_shift;
  logic [31:0]       w_wdata;
  logic              w_active;
  logic              w_invalid;
  logic              w_do_write;
  logic [31:0]       w_rd_word;
  logic [GPIO_W-1:0] w_sync_last;
  logic [GPIO_W-1:0] w_edge;

  assign w_off      = bus.i_req_addr - ADDR_START;
  assign w_in_range = (bus.i_req_addr >= ADDR_START) && (w_off < c_span);
  assign w_bank     = w_off[7:5];
  assign w_reg      = w_off[4:2];
  assign w_lane     = w_off[1:0];
  assign w_active   = (bus.i_req_count != c_cnt_none);

  always_comb begin
    w_aligned = 1'b0;
    w_mask    = 32'h0;
    w_shift   = 5'd0;
    case (bus.i_req_count)
      c_cnt_byte: begin
        w_aligned = 1'b1;
        w_shift   = {w_lane, 3'b000};
        w_mask    = 32'h0000_00FF << w_shift;
      end
      c_cnt_half: begin
        w_aligned = ~w_lane[0];
        w_shift   = {w_lane[1], 4'b0000};
        w_mask    = 32'h0000_FFFF << w_shift;
      end
      c_cnt_word: begin
        w_aligned = (w_lane == 2'd0);
        w_mask    = 32'hFFFF_FFFF;
      end
      default: ;
    endcase
  end

  // Data is shifted onto its lane and masked so aliases touch only that lane.
  assign w_wdata    = (bus.i_req_wr_data << w_shift) & w_mask;
  assign w_invalid  = !w_in_range || !w_aligned ||
                      (bus.i_req_wr_en && (w_reg == c_reg_in));
  assign w_do_write = w_active && !w_invalid && bus.i_req_wr_en;

  assign w_sync_last = r_sync[SYNC_STAGES-1];

  generate
    if (IRQ_EDGE == 0) begin : g_edge_rise
      assign w_edge = w_sync_last & ~r_hist;
    end else if (IRQ_EDGE == 1) begin : g_edge_fall
      assign w_edge = ~w_sync_last & r_hist;
    end else begin : g_edge_both
      assign w_edge = w_sync_last ^ r_hist;
    end
  endgenerate

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
      for (int b = 0; b < BANK_COUNT; b++) begin
        r_out[b] <= 32'h0;
        r_oe[b]  <= 32'h0;
        r_ie[b]  <= 32'h0;
        r_is[b]  <= 32'h0;
      end
    end else begin
      r_sync[0] <= i_gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= w_sync_last;
      for (int b = 0; b < BANK_COUNT; b++) begin
        if (w_do_write && (w_bank == 3'(b))) begin
          case (w_reg)
            c_reg_out: r_out[b] <= (r_out[b] & ~w_mask) | w_wdata;
            c_reg_set: r_out[b] <= r_out[b] | w_wdata;
            c_reg_clr: r_out[b] <= r_out[b] & ~w_wdata;
            c_reg_tgl: r_out[b] <= r_out[b] ^ w_wdata;
            c_reg_oe:  r_oe[b]  <= (r_oe[b] & ~w_mask) | w_wdata;
            c_reg_ie:  r_ie[b]  <= (r_ie[b] & ~w_mask) | w_wdata;
            default: ;
          endcase
        end
        // New edges are OR-ed after the clear so a coincident edge wins.
        r_is[b] <= (r_is[b] & ~((w_do_write && (w_bank == 3'(b)) &&
                                 (w_reg == c_reg_is)) ? w_wdata : 32'h0))
                   | w_edge[b*32 +: 32];
      end
    end
  end

  // IN returns the value the last sync stage takes at this edge, so a pin
  // change is readable SYNC_STAGES-1 edges after it is first sampled.
  always_comb begin
    w_rd_word = 32'h0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      if (w_bank == 3'(b)) begin
        case (w_reg)
          c_reg_out: w_rd_word = r_out[b];
          c_reg_oe:  w_rd_word = r_oe[b];
          c_reg_in:  w_rd_word = r_sync[SYNC_STAGES-2][b*32 +: 32];
          c_reg_ie:  w_rd_word = r_ie[b];
          c_reg_is:  w_rd_word = r_is[b];
          default:   w_rd_word = 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_code    <= c_code_none;
      r_rd_data <= 32'h0;
    end else if (!w_active) begin
      r_code    <= c_code_none;
      r_rd_data <= 32'h0;
    end else if (w_invalid) begin
      r_code    <= c_code_inv;
      r_rd_data <= 32'h0;
    end else if (bus.i_req_wr_en) begin
      r_code    <= c_code_write;
      r_rd_data <= 32'h0;
    end else begin
      r_code    <= c_code_read;
      r_rd_data <= (w_rd_word & w_mask) >> w_shift;
    end
  end

  assign bus.o_res_code    = r_code;
  assign bus.o_res_rd_data = r_rd_data;

  generate
    for (genvar gb = 0; gb < BANK_COUNT; gb++) begin : g_pins
      assign o_gpio_out[gb*32 +: 32] = r_out[gb];
      assign o_gpio_oe[gb*32 +: 32]  = r_oe[gb];
    end
  endgenerate

  always_comb begin
    o_irq = 1'b0;
    for (int b = 0; b < BANK_COUNT; b++) o_irq = o_irq | (|(r_is[b] & r_ie[b]));
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_controller.sv
// ============================================================================
//  Module   : tb_gpio_controller
//  Brief    : Directed self-checking bench for gpio_controller (2 banks).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_controller;
  localparam logic [1:0] c_none  = 2'd0;
  localparam logic [1:0] c_byte  = 2'd1;
  localparam logic [1:0] c_half  = 2'd2;
  localparam logic [1:0] c_word  = 2'd3;
  localparam logic [1:0] c_read  = 2'd1;
  localparam logic [1:0] c_write = 2'd2;
  localparam logic [1:0] c_inv   = 2'd3;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [63:0] r_gpio_in = 64'h0;
  logic [63:0] w_gpio_out;
  logic [63:0] w_gpio_oe;
  logic        w_irq;
  logic [31:0] r_rd;
  logic [1:0]  r_code;
  int          n_checks = 0;
  int          n_pass   = 0;

  gpio_controller_if bus ();

  gpio_controller #(
    .ADDR_START (32'h100),
    .BANK_COUNT (2),
    .SYNC_STAGES(2),
    .IRQ_EDGE   (0)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .bus       (bus),
    .i_gpio_in (r_gpio_in),
    .o_gpio_out(w_gpio_out),
    .o_gpio_oe (w_gpio_oe),
    .o_irq     (w_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called 1ns after a rising edge; presents the request for the next edge.
  task automatic req(input logic [1:0] cnt, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data);
    bus.i_req_count   = cnt;
    bus.i_req_wr_en   = wr;
    bus.i_req_addr    = addr;
    bus.i_req_wr_data = data;
    @(posedge clk); #1;
    r_rd   = bus.o_res_rd_data;
    r_code = bus.o_res_code;
    bus.i_req_count = c_none;
    bus.i_req_wr_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_req_count   = c_none;
    bus.i_req_wr_en   = 1'b0;
    bus.i_req_addr    = 32'h0;
    bus.i_req_wr_data = 32'h0;
    cycles(2);
    check("rst_out",  w_gpio_out, 64'h0);
    check("rst_code", {62'h0, bus.o_res_code}, 64'h0);
    areset = 1'b0;

    req(c_word, 1'b1, 32'h100, 32'hdeadbeef);
    check("pre_wr_code", {62'h0, r_code}, {62'h0, c_write});
    check("pre_wr_out",  w_gpio_out, 64'h0000_0000_dead_beef);

    // Reset asserted in the middle of a write.
    bus.i_req_count = c_word; bus.i_req_wr_en = 1'b1;
    bus.i_req_addr = 32'h100; bus.i_req_wr_data = 32'hdeadbeef;
    #2 areset = 1'b1;
    #1;
    check("arst_out",  w_gpio_out, 64'h0);
    check("arst_oe",   w_gpio_oe, 64'h0);
    check("arst_irq",  {63'h0, w_irq}, 64'h0);
    check("arst_code", {62'h0, bus.o_res_code}, 64'h0);
    check("arst_rd",   {32'h0, bus.o_res_rd_data}, 64'h0);
    cycles(1);
    check("arst_hold", w_gpio_out, 64'h0);
    bus.i_req_count = c_none; bus.i_req_wr_en = 1'b0;
    areset = 1'b0;
    req(c_word, 1'b0, 32'h100, 32'h0);
    check("rst_rd_code", {62'h0, r_code}, {62'h0, c_read});
    check("rst_rd_out",  {32'h0, r_rd}, 64'h0);

    req(c_word, 1'b1, 32'h120, 32'hdeadbeef);
    check("b1_wr_code", {62'h0, r_code}, {62'h0, c_write});
    check("b1_out",     w_gpio_out, 64'hdead_beef_0000_0000);
    req(c_word, 1'b1, 32'h12C, 32'h0000_0010);
    check("set_out", w_gpio_out, 64'hdead_beff_0000_0000);
    req(c_word, 1'b1, 32'h130, 32'h0000_000F);
    check("clr_out", w_gpio_out, 64'hdead_bef0_0000_0000);
    req(c_word, 1'b1, 32'h134, 32'hF000_0000);
    check("tgl_out", w_gpio_out, 64'h2ead_bef0_0000_0000);
    req(c_word, 1'b0, 32'h120, 32'h0);
    check("b1_rd", {32'h0, r_rd}, 64'h2ead_bef0);
    req(c_word, 1'b0, 32'h12C, 32'h0);
    check("set_rd_code", {62'h0, r_code}, {62'h0, c_read});
    check("set_rd_zero", {32'h0, r_rd}, 64'h0);

    req(c_byte, 1'b1, 32'h106, 32'h0000_00AA);
    check("oe_byte",  w_gpio_oe, 64'h0000_0000_00AA_0000);
    req(c_half, 1'b0, 32'h106, 32'h0);
    check("oe_half_rd", {32'h0, r_rd}, 64'h0000_00AA);

    req(c_half, 1'b1, 32'h105, 32'h0000_FFFF);
    check("err_half_code", {62'h0, r_code}, {62'h0, c_inv});
    check("err_half_oe",   w_gpio_oe, 64'h0000_0000_00AA_0000);
    req(c_word, 1'b0, 32'h107, 32'h0);
    check("err_word_code", {62'h0, r_code}, {62'h0, c_inv});
    check("err_word_rd",   {32'h0, r_rd}, 64'h0);
    req(c_word, 1'b0, 32'h140, 32'h0);
    check("err_hi_code", {62'h0, r_code}, {62'h0, c_inv});
    req(c_word, 1'b1, 32'h0FC, 32'hFFFF_FFFF);
    check("err_lo_code", {62'h0, r_code}, {62'h0, c_inv});
    check("err_lo_out",  w_gpio_out, 64'h2ead_bef0_0000_0000);
    req(c_word, 1'b1, 32'h108, 32'hFFFF_FFFF);
    check("err_in_code", {62'h0, r_code}, {62'h0, c_inv});

    r_gpio_in[31:0] = 32'h1234_5678;
    req(c_word, 1'b0, 32'h108, 32'h0);
    check("in_early", {32'h0, r_rd}, 64'h0);
    req(c_word, 1'b0, 32'h108, 32'h0);
    check("in_new", {32'h0, r_rd}, 64'h1234_5678);
    cycles(2);
    req(c_word, 1'b0, 32'h11C, 32'h0);
    check("is_b0", {32'h0, r_rd}, 64'h1234_5678);
    check("irq_ie0", {63'h0, w_irq}, 64'h0);
    req(c_word, 1'b1, 32'h11C, 32'hFFFF_FFFF);
    req(c_word, 1'b0, 32'h11C, 32'h0);
    check("is_b0_clr", {32'h0, r_rd}, 64'h0);

    req(c_word, 1'b1, 32'h138, 32'h0000_0020);
    r_gpio_in[37] = 1'b1;
    cycles(2);
    check("irq_early", {63'h0, w_irq}, 64'h0);
    cycles(1);
    check("irq_rise", {63'h0, w_irq}, 64'h1);
    req(c_word, 1'b1, 32'h13C, 32'h0000_0020);
    check("irq_w1c", {63'h0, w_irq}, 64'h0);
    r_gpio_in[37] = 1'b0;
    cycles(4);
    check("irq_fall", {63'h0, w_irq}, 64'h0);
    req(c_word, 1'b0, 32'h13C, 32'h0);
    check("is_fall", {32'h0, r_rd}, 64'h0);

    r_gpio_in[37] = 1'b1;
    cycles(2);
    req(c_word, 1'b1, 32'h13C, 32'h0000_0020);
    check("irq_set_wins", {63'h0, w_irq}, 64'h1);
    req(c_word, 1'b0, 32'h13C, 32'h0);
    check("is_set_wins", {32'h0, r_rd}, 64'h20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/gpio_controller.md
# gpio_controller

Memory-mapped, multi-bank GPIO controller on the core's data-memory request/response bus. It is the successor to the single-function GPIO interface. Per bank it provides:

- output and output-enable registers;
- atomic set/clear/toggle aliases;
- synchronised input sampling;
- per-pin edge-triggered interrupts with write-1-to-clear status, merged into one interrupt line to the core.

## Interface

Parameters:

- ADDR_START, 0: byte address of bank 0, register 0. Must be 32-byte aligned.
- BANK_COUNT, 1: number of 32-pin banks, 1..8. GPIO_W = BANK_COUNT * `WORD_W.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- IRQ_EDGE, 0: interrupt edge. 0 = rising, 1 = falling, 2 = both.

Ports:

- clk  in  1  system clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- i_req_addr  in  `ADDR_W  byte address.
- i_req_wr_data  in  `WORD_W  write data, right-justified for byte/half.
- i_req_wr_en  in  1  1 = write, 0 = read.
- i_req_count  in  `MEM_COUNT_W  NONE/BYTE/HALF/WORD; NONE = idle.
- o_res_rd_data  out  `WORD_W  read data, zero-extended, right-justified.
- o_res_code  out  `MEM_CODE_W  response code from mem_codes.vh.
- i_gpio_in  in  GPIO_W  asynchronous pin inputs.
- o_gpio_out  out  GPIO_W  OUT registers.
- o_gpio_oe  out  GPIO_W  OE registers; 1 = drive.
- o_irq  out  1  level interrupt.

## Operation

- Decode:
  - off = i_req_addr - ADDR_START.
  - bank = off[7:5].
  - reg = off[4:2].
  - lane = off[1:0].
  - In range iff i_req_addr >= ADDR_START and off < BANK_COUNT*32.
- Per-bank registers, by word offset:
  - 0x00 OUT (RW).
  - 0x04 OE (RW).
  - 0x08 IN (RO, synchronised pins).
  - 0x0C SET (WO; OUT |= d).
  - 0x10 CLR (WO; OUT &= ~d).
  - 0x14 TGL (WO; OUT ^= d).
  - 0x18 IE (RW).
  - 0x1C IS (read; write-1-to-clear).
- Reads of SET/CLR/TGL return 0 with code READ.
- Sub-word access:
  - BYTE selects lane.
  - HALF selects half addr[1] and requires addr[0]=0.
  - WORD requires lane=0.
  - Write data is taken from the low 8/16/32 bits and applied to the selected lane only. SET/CLR/TGL/IS act only on that lane; other lanes are untouched.
- Response codes:
  - Legal read: MEM_CODE_READ.
  - Legal write: MEM_CODE_WRITE.
  - INVALID: out of range, misaligned, or write to IN. No state change and rd_data = 0.
  - Idle (count NONE): MEM_CODE_NONE, rd_data 0.
- Input path:
  - i_gpio_in passes through a SYNC_STAGES flop chain; IN reads the last stage.
  - A history flop holds the previous synchronised value.
  - An edge per IRQ_EDGE sets the IS bit, regardless of IE.
- o_irq = OR over all banks of (IS & IE). It is combinational from registers.
- Simultaneous edge detection and W1C of the same IS bit: set wins and the bit stays 1.
- Every cycle with count != NONE is an independent request. There is no back-pressure.

## Timing

- Request sampled at rising edge N; o_res_code and o_res_rd_data are registered and valid after edge N (one-cycle latency). They are held until the next edge only.
- Register writes take effect at edge N; o_gpio_out/o_gpio_oe change after edge N.
- A read at N+1 returns the value written at N (read-after-write with no bubble).
- A pin change settling before edge K:
  - appears in IN, readable by a request at edge K+SYNC_STAGES-1;
  - sets IS after edge K+SYNC_STAGES;
  - raises o_irq in the same cycle IS sets, if IE=1.
- Reset (areset=1, asynchronous): immediately and while asserted, all of the following are 0:
  - OUT, OE, IE, IS, sync chain and history;
  - o_gpio_out, o_gpio_oe, o_irq, o_res_rd_data;
  - o_res_code = MEM_CODE_NONE.

  A request in flight is dropped with no response. After release, a pin already high is seen as a rising edge once synchronised.
- Reset deassertion is synchronous to clk externally; the block assumes it.

## Test plan

- Reset: areset=1 mid-write of OUT=0xdeadbeef -> all outputs 0 and code NONE at once. After release, word read of OUT returns 0x00000000, code READ.
- Word write/alias, ADDR_START=0x100, BANK_COUNT=2:
  - write OUT@0x120=0xdeadbeef gives code WRITE, and o_gpio_out[63:32]=0xdeadbeef.
  - SET@0x12C=0x10, CLR@0x130=0x0F, TGL@0x134=0xF0000000 lead to OUT=0x2eadbef0.
- Sub-word: byte write 0xAA at OE offset lane 2 -> OE=0x00AA0000. Half read lane 2 returns 0x000000AA.
- Errors, each giving INVALID with no state change:
  - HALF at lane 1;
  - WORD at lane 3;
  - address 0x140;
  - address 0x0FC;
  - write to IN.
- Interrupt, IRQ_EDGE=0, SYNC_STAGES=2:
  - IE bit 5 set; pin 5 rises before edge K -> IS bit 5 and o_irq=1 after edge K+2.
  - Falling edge -> no new set.
  - W1C 0x20 -> o_irq=0 next cycle.
  - A W1C coinciding with a new edge leaves IS=1.
- Input read: drive i_gpio_in=0x12345678 -> a read of IN at the 2nd edge after the change returns 0x12345678. A read one edge earlier returns the old value.
